// File: rtl/line_buffer_window.sv
// -----------------------------------------------------------------------------
// line_buffer_window
//
// Streaming sliding-window generator feeding the convolution stage. Pixels
// arrive in raster order, one per pixel_valid cycle, with no stall path.
// KERNEL_SIZE-1 previous image rows are held in line buffers. A
// KERNEL_SIZE x KERNEL_SIZE register array holds the current neighbourhood.
// Every pixel that completes a full neighbourhood produces one flattened
// window, registered, with a one-cycle strobe.
//
// Parameters
//   DATA_WIDTH  : pixel width in bits
//   KERNEL_SIZE : window side length (>= 2)
//   IMG_WIDTH   : pixels per row (>= KERNEL_SIZE)
//   IMG_HEIGHT  : rows per frame (>= KERNEL_SIZE)
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   pixel_in     : incoming pixel, raster order
//   pixel_valid  : pixel_in is accepted on this cycle's rising edge
//   window_out   : flattened window. Element (0,0) (oldest row, left column)
//                  is in the MSBs. Element (K-1,K-1) is in the LSBs.
//   window_valid : window_out carries a new window this cycle
//   frame_done   : pulses together with the last window of a frame
// -----------------------------------------------------------------------------
module line_buffer_window #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [DATA_WIDTH-1:0]                     pixel_in,
  input  logic                                      pixel_valid,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                      window_valid,
  output logic                                      frame_done
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_EMIT  = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_EMIT  = ROW_W'(KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0] COL_STEP  = COL_W'(1'b1);
  localparam logic [ROW_W-1:0] ROW_STEP  = ROW_W'(1'b1);

  // Position of the pixel presented this cycle.
  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;

  // Line buffers. Index 0 is the oldest row and index KERNEL_SIZE-2 is the
  // row just above the current one. They have no reset: a window only
  // appears after KERNEL_SIZE-1 rows of the current frame have overwritten
  // every location that can be read.
  logic [DATA_WIDTH-1:0] lb_mem [KERNEL_SIZE-1][IMG_WIDTH];

  // Current window array, [row i][column j], i=0 top and j=0 left.
  logic [DATA_WIDTH-1:0] win_r      [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] win_next_s [KERNEL_SIZE][KERNEL_SIZE];

  // Incoming right-hand column: the line-buffer reads at col, then pixel_in.
  logic [DATA_WIDTH-1:0] new_col_s  [KERNEL_SIZE];

  logic [KK*DATA_WIDTH-1:0] pack_s;
  logic                     col_last_s;
  logic                     row_last_s;
  logic                     emit_s;
  logic                     frame_end_s;

  // Position decode and emission qualification for the pixel on the input.
  always_comb begin
    col_last_s  = (col_r == COL_LAST);
    row_last_s  = (row_r == ROW_LAST);
    frame_end_s = col_last_s && row_last_s;
    if (pixel_valid && (row_r >= ROW_EMIT) && (col_r >= COL_EMIT)) begin
      emit_s = 1'b1;
    end else begin
      emit_s = 1'b0;
    end
  end

  // Assemble the new column from the line-buffer reads and the live pixel.
  always_comb begin
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      new_col_s[k] = '0;
    end
    for (int k = 0; k < KERNEL_SIZE - 1; k++) begin
      new_col_s[k] = lb_mem[k][col_r];
    end
    new_col_s[KERNEL_SIZE-1] = pixel_in;
  end

  // Next window: shift every row left by one column and append the new column.
  always_comb begin
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
        win_next_s[i][j] = win_r[i][j+1];
      end
      win_next_s[i][KERNEL_SIZE-1] = new_col_s[i];
    end
  end

  // Flatten the next window so element (0,0) lands in the MSBs.
  always_comb begin
    pack_s = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        pack_s[(KK - (i*KERNEL_SIZE + j))*DATA_WIDTH-1 -: DATA_WIDTH] = win_next_s[i][j];
      end
    end
  end

  // Raster position counters. Both wrap at the frame's last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= '0;
      row_r <= '0;
    end else if (pixel_valid) begin
      if (col_last_s) begin
        col_r <= '0;
        if (row_last_s) begin
          row_r <= '0;
        end else begin
          row_r <= row_r + ROW_STEP;
        end
      end else begin
        col_r <= col_r + COL_STEP;
        row_r <= row_r;
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Line buffers shift one row upward at the current column on every
  // accepted pixel. The oldest entry drops out and pixel_in enters at the bottom.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      for (int k = 0; k < KERNEL_SIZE - 2; k++) begin
        lb_mem[k][col_r] <= lb_mem[k+1][col_r];
      end
      lb_mem[KERNEL_SIZE-2][col_r] <= pixel_in;
    end
  end

  // Window array advances on every accepted pixel, including non-emitting
  // ones, so it is already primed when the first qualifying column arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        for (int j = 0; j < KERNEL_SIZE; j++) begin
          win_r[i][j] <= '0;
        end
      end
    end else if (pixel_valid) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        for (int j = 0; j < KERNEL_SIZE; j++) begin
          win_r[i][j] <= win_next_s[i][j];
        end
      end
    end else begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        for (int j = 0; j < KERNEL_SIZE; j++) begin
          win_r[i][j] <= win_r[i][j];
        end
      end
    end
  end

  // Registered outputs. window_out is loaded only when a window is emitted,
  // so it holds the last emitted window through idle and non-emitting cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_out   <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else if (emit_s) begin
      window_out   <= pack_s;
      window_valid <= 1'b1;
      frame_done   <= frame_end_s;
    end else begin
      window_out   <= window_out;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buffer_window.sv
module tb_line_buffer_window;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int KK = K * K;
  localparam int WW = KK * DW;

  typedef logic [WW-1:0] win_t;
  typedef struct packed {
    win_t win;
    logic fd;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] pixel_in;
  logic          pixel_valid;
  win_t          window_out;
  logic          window_valid;
  logic          frame_done;

  exp_t exp_q[$];
  win_t cap[$];
  logic cap_fd[$];
  win_t ref_q[$];
  win_t prev_out;
  exp_t e_mon;

  int checks   = 0;
  int failures = 0;

  line_buffer_window #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(K),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .window_out  (window_out),
    .window_valid(window_valid),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_w(input string name, input win_t act, input win_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected window for pixel (r,c) of an image whose pixel(r,c) = base + r*W + c.
  function automatic win_t exp_win(input int base, input int r, input int c);
    win_t w;
    w = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        w[(KK - (i*K + j))*DW-1 -: DW] = DW'(base + (r-K+1+i)*W + (c-K+1+j));
      end
    end
    return w;
  endfunction

  // Hand-listed window, elements in row-major order, first one in the MSBs.
  function automatic win_t pack9(input int e0, input int e1, input int e2,
                                 input int e3, input int e4, input int e5,
                                 input int e6, input int e7, input int e8);
    return {DW'(e0), DW'(e1), DW'(e2), DW'(e3), DW'(e4), DW'(e5), DW'(e6), DW'(e7), DW'(e8)};
  endfunction

  function automatic win_t cap_at(input int i);
    if (i < cap.size()) return cap[i];
    return '0;
  endfunction

  function automatic int fd_at(input int i);
    if (i < cap_fd.size()) return int'(cap_fd[i]);
    return -1;
  endfunction

  task automatic send(input int base, input int r, input int c);
    exp_t e;
    @(posedge clk);
    #1;
    pixel_valid = 1'b1;
    pixel_in    = DW'(base + r*W + c);
    if (r >= K-1 && c >= K-1) begin
      e.win = exp_win(base, r, c);
      e.fd  = (r == H-1) && (c == W-1);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      pixel_in    = DW'($urandom);
    end
  endtask

  task automatic send_frame(input int base, input int max_gap);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(base, r, c);
        if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a window.
  always @(negedge clk) begin
    if (rst_n) begin
      if (window_valid) begin
        cap.push_back(window_out);
        cap_fd.push_back(frame_done);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_window actual=%h required=none", window_out);
        end else begin
          e_mon = exp_q.pop_front();
          chk_w("window", window_out, e_mon.win);
          chk_i("frame_done", int'(frame_done), int'(e_mon.fd));
        end
      end else begin
        chk_i("frame_done_idle", int'(frame_done), 0);
        chk_w("hold_out", window_out, prev_out);
      end
      prev_out = window_out;
    end else begin
      prev_out = '0;
    end
  end

  initial begin
    rst_n       = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    prev_out    = '0;

    // Reset held with random input activity.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      pixel_valid = 1'($urandom);
      pixel_in    = DW'($urandom);
      @(negedge clk);
      chk_w("rst_window_out", window_out, '0);
      chk_i("rst_window_valid", int'(window_valid), 0);
      chk_i("rst_frame_done", int'(frame_done), 0);
    end
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    rst_n       = 1'b1;

    // Full frame with continuous valid.
    cap.delete(); cap_fd.delete();
    send_frame(0, 0);
    idle(3);
    chk_i("f1_count", cap.size(), 36);
    chk_w("f1_first", cap_at(0), pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    chk_w("f1_rowwrap", cap_at(6), pack9(8, 9, 10, 16, 17, 18, 24, 25, 26));
    chk_w("f1_last", cap_at(35), pack9(45, 46, 47, 53, 54, 55, 61, 62, 63));
    chk_i("f1_last_fd", fd_at(35), 1);
    chk_i("f1_first_fd", fd_at(0), 0);
    ref_q = cap;

    // Same frame with random idle gaps.
    cap.delete(); cap_fd.delete();
    send_frame(0, 3);
    idle(3);
    chk_i("gap_count", cap.size(), 36);
    for (int i = 0; i < 36; i++) begin
      chk_w("gap_window", cap_at(i), ref_q[i]);
    end

    // Back-to-back frames, second frame offset by 100.
    cap.delete(); cap_fd.delete();
    send_frame(0, 0);
    for (int idx = 0; idx < 18; idx++) send(100, idx / W, idx % W);
    idle(3);
    chk_i("b2b_no_early", cap.size(), 36);
    for (int idx = 18; idx < W*H; idx++) send(100, idx / W, idx % W);
    idle(3);
    chk_i("b2b_count", cap.size(), 72);
    chk_w("b2b_first_f2", cap_at(36), pack9(100, 101, 102, 108, 109, 110, 116, 117, 118));
    chk_i("b2b_fd_f1", fd_at(35), 1);
    chk_i("b2b_fd_f2", fd_at(71), 1);

    // Mid-frame reset after 20 pixels, then a fresh frame.
    cap.delete(); cap_fd.delete();
    for (int idx = 0; idx < 20; idx++) send(50, idx / W, idx % W);
    idle(2);
    chk_i("mid_pre_count", cap.size(), 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_w("mid_rst_window_out", window_out, '0);
    chk_i("mid_rst_window_valid", int'(window_valid), 0);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      pixel_valid = 1'($urandom);
      pixel_in    = DW'($urandom);
      @(negedge clk);
      chk_w("mid_hold_window_out", window_out, '0);
      chk_i("mid_hold_valid", int'(window_valid) | int'(frame_done), 0);
    end
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    rst_n       = 1'b1;
    cap.delete(); cap_fd.delete();
    send_frame(200, 0);
    idle(3);
    chk_i("fresh_count", cap.size(), 36);
    chk_w("fresh_first", cap_at(0), pack9(200, 201, 202, 208, 209, 210, 216, 217, 218));
    chk_i("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
